// File: rtl/lane_mon_pkg.sv
// Shared definitions for the Aurora lane frame monitor and the matching TX
// frame generator: LFSR taps and default seed, FSM encoding, and a
// saturating counter increment.
package lane_mon_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  // Fibonacci taps at bits 15, 13, 12 and 10
  localparam logic [DATA_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [DATA_W-1:0] DEFAULT_SEED = 16'hD5A3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } mon_state_e;

  // One LFSR step: shift left, feedback into bit 0
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

  // Increment when en is set, holding at all-ones
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != {CNT_W{1'b1}})) return v + CNT_W'(1);
    return v;
  endfunction

endpackage

// File: rtl/lane_frame_monitor_if.sv
// LocalLink receive bus of one lane.
//   master : drives rx_data, rx_sof_n, rx_eof_n, rx_dvalid_n (transceiver side)
//   slave  : samples the same signals (monitor side)
interface lane_frame_monitor_if;
  import lane_mon_pkg::*;

  logic [DATA_W-1:0] rx_data;
  logic              rx_sof_n;
  logic              rx_eof_n;
  logic              rx_dvalid_n;

  modport master (output rx_data, output rx_sof_n, output rx_eof_n, output rx_dvalid_n);
  modport slave  (input  rx_data, input  rx_sof_n, input  rx_eof_n, input  rx_dvalid_n);
endinterface

// File: rtl/lane_lfsr16.sv
// 16-bit Fibonacci LFSR shared by the TX generator and RX monitor.
//   clk, rst : clock, async active-high reset (loads SEED)
//   load_i   : restart the sequence from SEED
//   adv_i    : advance one step (applied after a same-cycle load)
//   lfsr_o   : current register value
module lane_lfsr16
  import lane_mon_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [DATA_W-1:0] lfsr_o
);

  logic [DATA_W-1:0] lfsr_q;
  logic [DATA_W-1:0] lfsr_d;
  logic [DATA_W-1:0] base;

  // Load picks the starting point, advance steps from it
  always_comb begin
    base   = load_i ? SEED : lfsr_q;
    lfsr_d = adv_i ? lfsr_next(base) : base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/lane_frame_monitor.sv
// Receive-side LocalLink checker for one Aurora lane: checks payload against
// the LFSR sequence, SOF/EOF pairing and (optionally) frame length, and keeps
// saturating packet/error counters plus a sticky error flag.
// Optional feature macro: LANE_MON_LEN_CHECK_EN enables MIN_LEN/MAX_LEN checks
// on EOF (beat counter built only then).
//   clk_gtp, rst_gtp : lane clock, async active-high reset
//   channel_up       : low forces IDLE and silently drops the open frame
//   cnt_clr          : synchronous clear of counters and sticky flag
//   rx               : LocalLink receive bus (slave modport)
//   pkt_cnt, err_cnt : good frames / error events, saturating
//   err_pulse        : one-cycle strobe per error event
//   err_sticky       : set on first error
//   in_frame         : FSM is in FRAME
module lane_frame_monitor
  import lane_mon_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED    = DEFAULT_SEED,
  parameter int unsigned       MIN_LEN = 2,
  parameter int unsigned       MAX_LEN = 256
) (
  input  logic                 clk_gtp,
  input  logic                 rst_gtp,
  input  logic                 channel_up,
  input  logic                 cnt_clr,
  lane_frame_monitor_if.slave  rx,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic                 in_frame
);

  // Reject inconsistent length limits at elaboration
  if ((MIN_LEN > MAX_LEN) || (MIN_LEN == 0)) begin : g_len_cfg_bad
    $error("lane_frame_monitor: MIN_LEN must be in 1..MAX_LEN");
  end

  mon_state_e        state_q, state_d;
  logic              bad_q, bad_d;
  logic [CNT_W-1:0]  pkt_q, pkt_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              pulse_q, pulse_d;
  logic              sticky_q, sticky_d;

  logic              beat, rx_sof, rx_eof;
  logic              frame_beat, orphan, abort;
  logic              mismatch, len_err, err_evt, pkt_evt, bad_now;
  logic [DATA_W-1:0] lfsr_val;

  // Beat qualification; SOF/EOF only count on valid beats with the lane up
  assign beat       = channel_up && !rx.rx_dvalid_n;
  assign rx_sof     = beat && !rx.rx_sof_n;
  assign rx_eof     = beat && !rx.rx_eof_n;
  assign frame_beat = rx_sof || (beat && (state_q == ST_FRAME));
  assign orphan     = beat && !rx_sof && (state_q == ST_IDLE);
  assign abort      = rx_sof && (state_q == ST_FRAME);

  // Register holds the word expected on the next non-SOF beat
  lane_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk    (clk_gtp),
    .rst    (rst_gtp),
    .load_i (rx_sof),
    .adv_i  (frame_beat),
    .lfsr_o (lfsr_val)
  );

`ifdef LANE_MON_LEN_CHECK_EN
  localparam int unsigned BEAT_W = 9;

  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d, beats_now;

  // beats_now counts the current beat too, so EOF sees the full length
  always_comb begin
    beats_now  = rx_sof ? BEAT_W'(1)
               : ((beat_cnt_q == {BEAT_W{1'b1}}) ? beat_cnt_q : beat_cnt_q + BEAT_W'(1));
    beat_cnt_d = frame_beat ? beats_now : beat_cnt_q;
    len_err    = rx_eof && frame_beat &&
                 ((32'(beats_now) < MIN_LEN) || (32'(beats_now) > MAX_LEN));
  end

  always_ff @(posedge clk_gtp or posedge rst_gtp) begin
    if (rst_gtp) beat_cnt_q <= '0;
    else         beat_cnt_q <= beat_cnt_d;
  end
`else
  assign len_err = 1'b0;
`endif

  // Next-state, frame status and counter updates
  always_comb begin
    state_d  = state_q;
    bad_d    = bad_q;
    pkt_d    = pkt_q;
    err_d    = err_q;
    pulse_d  = 1'b0;
    sticky_d = sticky_q;

    mismatch = frame_beat && (rx.rx_data != (rx_sof ? SEED : lfsr_val));
    err_evt  = mismatch || orphan || abort || len_err;
    // A SOF starts a fresh frame, so earlier badness does not carry over
    bad_now  = (rx_sof ? 1'b0 : bad_q) || mismatch || len_err;
    pkt_evt  = rx_eof && frame_beat && !bad_now;

    if (frame_beat) bad_d = bad_now;

    if (!channel_up)  state_d = ST_IDLE;
    else if (rx_sof)  state_d = rx_eof ? ST_IDLE : ST_FRAME;
    else if (rx_eof)  state_d = ST_IDLE;

    if (cnt_clr) begin
      pkt_d    = '0;
      err_d    = '0;
      sticky_d = 1'b0;
    end else begin
      pkt_d    = sat_inc(pkt_q, pkt_evt);
      err_d    = sat_inc(err_q, err_evt);
      sticky_d = sticky_q || err_evt;
      pulse_d  = err_evt;
    end
  end

  always_ff @(posedge clk_gtp or posedge rst_gtp) begin
    if (rst_gtp) begin
      state_q  <= ST_IDLE;
      bad_q    <= 1'b0;
      pkt_q    <= '0;
      err_q    <= '0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bad_q    <= bad_d;
      pkt_q    <= pkt_d;
      err_q    <= err_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
    end
  end

  assign pkt_cnt    = pkt_q;
  assign err_cnt    = err_q;
  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign in_frame   = (state_q == ST_FRAME);

endmodule

// File: tb/tb_lane_frame_monitor.sv
// Randomized self-checking bench for lane_frame_monitor with a frame-level
// reference model (beat index within frame, expected word = SEED stepped idx times).
module tb_lane_frame_monitor;

  localparam logic [15:0] SEED = 16'hD5A3;

  logic        clk_gtp    = 1'b0;
  logic        rst_gtp    = 1'b1;
  logic        channel_up = 1'b0;
  logic        cnt_clr    = 1'b0;
  logic [15:0] pkt_cnt, err_cnt;
  logic        err_pulse, err_sticky, in_frame;

  lane_frame_monitor_if rx_if ();

  lane_frame_monitor dut (
    .clk_gtp    (clk_gtp),
    .rst_gtp    (rst_gtp),
    .channel_up (channel_up),
    .cnt_clr    (cnt_clr),
    .rx         (rx_if),
    .pkt_cnt    (pkt_cnt),
    .err_cnt    (err_cnt),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .in_frame   (in_frame)
  );

  always #5 clk_gtp = ~clk_gtp;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_in_frame, m_idx, m_bad, m_pkt, m_err, m_sticky, m_pulse;

  function automatic logic [15:0] exp_word(input int idx);
    logic [15:0] w;
    w = SEED;
    for (int i = 0; i < idx; i++) w = {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
    return w;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_idx = 0; m_bad = 0;
    m_pkt = 0; m_err = 0; m_sticky = 0; m_pulse = 0;
  endtask

  // Apply one clock cycle of inputs to the model
  task automatic model_cycle(input bit cu, input bit clr, input bit dv_n,
                             input bit sof_n, input bit eof_n, input logic [15:0] d);
    int ev, pev, owned;
    ev = 0; pev = 0; owned = 1;
    if (!cu) begin
      m_in_frame = 0;
    end else if (!dv_n) begin
      if (!sof_n) begin
        if (m_in_frame != 0) ev = 1;
        m_in_frame = 1; m_idx = 0; m_bad = 0;
      end else if (m_in_frame == 0) begin
        ev = 1; owned = 0;
      end
      if (owned != 0) begin
        if (d !== exp_word(m_idx)) begin ev = 1; m_bad = 1; end
        m_idx++;
        if (!eof_n) begin
`ifdef LANE_MON_LEN_CHECK_EN
          if (m_idx < 2 || m_idx > 256) begin ev = 1; m_bad = 1; end
`endif
          if (m_bad == 0) pev = 1;
          m_in_frame = 0;
        end
      end
    end
    if (clr) begin
      m_pkt = 0; m_err = 0; m_sticky = 0; m_pulse = 0;
    end else begin
      if (pev != 0 && m_pkt < 65535) m_pkt++;
      if (ev != 0 && m_err < 65535) m_err++;
      if (ev != 0) m_sticky = 1;
      m_pulse = ev;
    end
  endtask

  task automatic check_outputs();
    chk("pkt_cnt",    int'(pkt_cnt),    m_pkt);
    chk("err_cnt",    int'(err_cnt),    m_err);
    chk("err_pulse",  int'(err_pulse),  m_pulse);
    chk("err_sticky", int'(err_sticky), m_sticky);
    chk("in_frame",   int'(in_frame),   m_in_frame);
  endtask

  // Drive one cycle (called just after a falling edge), compare after it
  task automatic step(input bit cu, input bit clr, input bit dv_n,
                      input bit sof_n, input bit eof_n, input logic [15:0] d);
    channel_up        = cu;
    cnt_clr           = clr;
    rx_if.rx_dvalid_n = dv_n;
    rx_if.rx_sof_n    = sof_n;
    rx_if.rx_eof_n    = eof_n;
    rx_if.rx_data     = d;
    model_cycle(cu, clr, dv_n, sof_n, eof_n, d);
    @(posedge clk_gtp);
    @(negedge clk_gtp);
    check_outputs();
  endtask

  task automatic beat(input logic [15:0] d, input bit sof, input bit eof);
    step(1'b1, 1'b0, 1'b0, !sof, !eof, d);
  endtask

  task automatic idle_cycle();
    step(1'b1, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 16'($urandom));
  endtask

  task automatic clear();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
  endtask

  task automatic send_frame(input int len, input int bad_beat, input logic [15:0] x);
    logic [15:0] d;
    for (int i = 0; i < len; i++) begin
      d = exp_word(i);
      if (i == bad_beat) d = d ^ x;
      beat(d, i == 0, i == len - 1);
    end
  endtask

  initial begin
    int r, n;
    rx_if.rx_dvalid_n = 1'b1;
    rx_if.rx_sof_n    = 1'b1;
    rx_if.rx_eof_n    = 1'b1;
    rx_if.rx_data     = 16'h0;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk_gtp);
    @(negedge clk_gtp);
    check_outputs();
    rst_gtp = 1'b0;

    // Pin the model's LFSR against a hand-computed step
    chk("lfsr_step1", int'(exp_word(1)), 32'hAB47);

    // Ten legal back-to-back 8-beat frames
    for (int f = 0; f < 10; f++) send_frame(8, -1, 16'h0);
    idle_cycle();
    chk("t1_pkt", int'(pkt_cnt), 10);
    chk("t1_err", int'(err_cnt), 0);
    chk("t1_sticky", int'(err_sticky), 0);
    clear();

    // Same stream, beat 3 of frame 4 corrupted
    for (int f = 0; f < 10; f++) send_frame(8, (f == 4) ? 3 : -1, 16'h0001);
    idle_cycle();
    chk("t2_pkt", int'(pkt_cnt), 9);
    chk("t2_err", int'(err_cnt), 1);
    chk("t2_sticky", int'(err_sticky), 1);
    clear();

    // SOF at beat 5 of an open frame, then a legal frame
    for (int i = 0; i < 4; i++) beat(exp_word(i), i == 0, 1'b0);
    send_frame(8, -1, 16'h0);
    idle_cycle();
    chk("t3_err", int'(err_cnt), 1);
    chk("t3_pkt", int'(pkt_cnt), 1);
    clear();

    // Orphan EOF, then single-beat frame
    beat(16'h1234, 1'b0, 1'b1);
    beat(SEED, 1'b1, 1'b1);
    idle_cycle();
`ifdef LANE_MON_LEN_CHECK_EN
    chk("t4_err", int'(err_cnt), 2);
    chk("t4_pkt", int'(pkt_cnt), 0);
`else
    chk("t4_err", int'(err_cnt), 1);
    chk("t4_pkt", int'(pkt_cnt), 1);
`endif
    clear();

    // channel_up dropped mid-frame, then raised, then a legal frame
    for (int i = 0; i < 3; i++) beat(exp_word(i), i == 0, 1'b0);
    chk("t5_in_frame_hi", int'(in_frame), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF);
    chk("t5_in_frame_lo", int'(in_frame), 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
    idle_cycle();
    send_frame(8, -1, 16'h0);
    idle_cycle();
    chk("t5_err", int'(err_cnt), 0);
    chk("t5_pkt", int'(pkt_cnt), 1);
    clear();

    // Length boundaries: exactly MAX_LEN and MAX_LEN+1
    send_frame(256, -1, 16'h0);
    send_frame(257, -1, 16'h0);
    idle_cycle();
`ifdef LANE_MON_LEN_CHECK_EN
    chk("t6_pkt", int'(pkt_cnt), 1);
    chk("t6_err", int'(err_cnt), 1);
`else
    chk("t6_pkt", int'(pkt_cnt), 2);
    chk("t6_err", int'(err_cnt), 0);
`endif
    clear();

    // Randomized traffic
    for (int a = 0; a < 400; a++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        n = int'($urandom_range(1, 12));
        if ($urandom_range(0, 4) == 0)
          send_frame(n, int'($urandom_range(0, 11)), 16'($urandom_range(1, 65535)));
        else
          send_frame(n, -1, 16'h0);
      end else if (r == 6) begin
        beat(16'($urandom), 1'b0, 1'($urandom));
      end else if (r == 7) begin
        n = int'($urandom_range(1, 3));
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 9) == 0) clear();
          else idle_cycle();
        end
      end else if (r == 8) begin
        n = int'($urandom_range(2, 5));
        for (int i = 0; i < n; i++) beat(exp_word(i), i == 0, 1'b0);
      end else begin
        n = int'($urandom_range(1, 2));
        for (int i = 0; i < n; i++)
          step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      end
    end
    idle_cycle();

    // Asynchronous reset in the middle of a frame
    send_frame(4, 1, 16'h0100);
    for (int i = 0; i < 3; i++) beat(exp_word(i), i == 0, 1'b0);
    rx_if.rx_dvalid_n = 1'b1;
    rst_gtp = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk_gtp);
    @(negedge clk_gtp);
    check_outputs();
    rst_gtp = 1'b0;
    send_frame(8, -1, 16'h0);
    idle_cycle();
    chk("t7_pkt", int'(pkt_cnt), 1);
    chk("t7_err", int'(err_cnt), 0);

    // Error counter saturation, then clear (event in the clear cycle is lost)
    clear();
    for (int i = 0; i < 65534; i++) beat(16'($urandom), 1'b0, 1'($urandom));
    chk("t8_err_fffe", int'(err_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) beat(16'($urandom), 1'b0, 1'b0);
    chk("t8_err_ffff", int'(err_cnt), 32'hFFFF);
    chk("t8_sticky", int'(err_sticky), 1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5555);
    chk("t8_clr_err", int'(err_cnt), 0);
    chk("t8_clr_pkt", int'(pkt_cnt), 0);
    chk("t8_clr_sticky", int'(err_sticky), 0);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
